// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, addresses the instruction ROM and
// fills the IF/ID register with sequential fetch, stall, flush and halt handling.
module instr_fetch_stage #(
    parameter logic [31:0] PC_RESET   = 32'd0,
    parameter int unsigned IMEM_WORDS = 7,
    parameter logic [31:0] NOP_WORD   = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        halted
);

    localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_WORDS);
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc_next;
    logic        pc_ok;

    assign imem_addr = pc;
    assign pc_next   = pc + PC_STEP;
    assign pc_ok     = (pc < PC_LIMIT) && (pc[1:0] == 2'b00);

    // Redirect beats stall; an unfetchable PC parks the unit in HALT with a bubble in IF/ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= PC_RESET;
            if_id_instr <= NOP_WORD;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (branch_taken) begin
                        pc          <= branch_target;
                        if_id_instr <= NOP_WORD;
                        if_id_pc4   <= '0;
                        if_id_valid <= 1'b0;
                    end else if (!freeze) begin
                        if (!pc_ok) begin
                            state       <= HALT;
                            halted      <= 1'b1;
                            if_id_instr <= NOP_WORD;
                            if_id_pc4   <= '0;
                            if_id_valid <= 1'b0;
                        end else begin
                            pc          <= pc_next;
                            if_id_instr <= imem_instr;
                            if_id_pc4   <= pc_next;
                            if_id_valid <= 1'b1;
                        end
                    end
                end
                HALT: state <= HALT;
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed vector table, async reset
// sequence and randomized run against a reference fetch model.
module tb_instr_fetch_stage;

    localparam int unsigned NWORDS = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch_stage #(
        .PC_RESET  (32'd0),
        .IMEM_WORDS(NWORDS),
        .NOP_WORD  (32'd0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .pc           (pc),
        .if_id_pc4    (if_id_pc4),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input int i);
        return 32'h2000_1000 + 32'(i) * 32'h0001_0003;
    endfunction

    // Combinational ROM; unpopulated or misaligned addresses return a poison word.
    always_comb begin
        if (imem_addr < 32'(4 * NWORDS) && imem_addr[1:0] == 2'b00)
            imem_instr = rom_word(int'(imem_addr >> 2));
        else
            imem_instr = 32'hDEAD_BEEF;
    end

    typedef struct {
        logic        do_rst;
        logic        fz;
        logic        bt;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_halted;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic f, input logic b, input logic [31:0] t,
                                input logic [31:0] p, input logic [31:0] p4, input logic [31:0] ins,
                                input logic v, input logic h);
        vec_t x;
        x.do_rst = r; x.fz = f; x.bt = b; x.tgt = t;
        x.e_pc = p; x.e_pc4 = p4; x.e_instr = ins; x.e_valid = v; x.e_halted = h;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model state
    logic [31:0] m_pc, m_pc4, m_instr;
    logic        m_valid, m_halted, m_boot;

    function automatic bit fetchable(input logic [31:0] a);
        return (a < 32'(4 * NWORDS)) && (a % 4 == 0);
    endfunction

    task automatic model_reset();
        m_pc = 32'd0; m_pc4 = 32'd0; m_instr = 32'd0;
        m_valid = 1'b0; m_halted = 1'b0; m_boot = 1'b1;
    endtask

    task automatic model_step(input logic f, input logic b, input logic [31:0] t);
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halted) begin
            // halt only exits through reset
        end else if (b) begin
            m_pc = t; m_instr = 32'd0; m_valid = 1'b0;
        end else if (f) begin
            // stall
        end else if (!fetchable(m_pc)) begin
            m_halted = 1'b1; m_instr = 32'd0; m_valid = 1'b0;
        end else begin
            m_instr = rom_word(int'(m_pc / 4));
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    task automatic check_state(input string tag, input logic [31:0] p, input logic [31:0] p4,
                               input logic [31:0] ins, input logic v, input logic h);
        chk({tag, " pc"}, pc, p);
        chk({tag, " imem_addr"}, imem_addr, p);
        chk({tag, " instr"}, if_id_instr, ins);
        chk({tag, " valid"}, 32'(if_id_valid), 32'(v));
        chk({tag, " halted"}, 32'(halted), 32'(h));
        if (v) chk({tag, " pc4"}, if_id_pc4, p4);
    endtask

    // Assert reset away from the edge, check reset values, release just after an edge.
    task automatic do_reset();
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        #2;
        check_state("reset", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("reset pc4", if_id_pc4, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic clock_with(input logic f, input logic b, input logic [31:0] t);
        freeze = f; branch_taken = b; branch_target = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;

        // Sequence A: boot, free-run through the ROM, halt at 28, ignore branch/freeze while halted.
        vecs.push_back(mk(1, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0));
        for (int k = 0; k < 7; k++)
            vecs.push_back(mk(0, 0, 0, 32'd0, 32'(4 * (k + 1)), 32'(4 * (k + 1)), rom_word(k), 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'd0, 32'd28, 32'd0, 32'd0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 32'd0, 32'd28, 32'd0, 32'd0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 32'd4, 32'd28, 32'd0, 32'd0, 0, 1));
        // Sequence B: freeze at 8, branch to 20, branch+freeze to 4, misaligned target 6 -> halt.
        vecs.push_back(mk(1, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'd0, 32'd4, 32'd4, rom_word(0), 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'd0, 32'd8, 32'd8, rom_word(1), 1, 0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0, 1, 0, 32'd0, 32'd8, 32'd8, rom_word(1), 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'd0, 32'd12, 32'd12, rom_word(2), 1, 0));
        vecs.push_back(mk(0, 0, 1, 32'd20, 32'd20, 32'd0, 32'd0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'd0, 32'd24, 32'd24, rom_word(5), 1, 0));
        vecs.push_back(mk(0, 1, 1, 32'd4, 32'd4, 32'd0, 32'd0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'd0, 32'd8, 32'd8, rom_word(1), 1, 0));
        vecs.push_back(mk(0, 0, 1, 32'd6, 32'd6, 32'd0, 32'd0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'd0, 32'd6, 32'd0, 32'd0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 32'd0, 32'd6, 32'd0, 32'd0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 32'd0, 32'd6, 32'd0, 32'd0, 0, 1));

        foreach (vecs[i]) begin
            if (vecs[i].do_rst) do_reset();
            clock_with(vecs[i].fz, vecs[i].bt, vecs[i].tgt);
            check_state($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_pc4,
                        vecs[i].e_instr, vecs[i].e_valid, vecs[i].e_halted);
        end

        // Asynchronous reset mid-run at pc=16 takes effect before the next edge.
        do_reset();
        repeat (5) clock_with(1'b0, 1'b0, 32'd0);
        check_state("pre_async", 32'd16, 32'd16, rom_word(3), 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_state("async_rst", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clock_with(1'b0, 1'b0, 32'd0);
        check_state("post_boot", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        clock_with(1'b0, 1'b0, 32'd0);
        check_state("post_fetch", 32'd4, 32'd4, rom_word(0), 1'b1, 1'b0);

        // Randomized run against the reference model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic        f, b;
            logic [31:0] t;
            int          r;
            f = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 6) == 0);
            r = int'($urandom_range(0, 9));
            if (r < 7)       t = 32'(4 * $urandom_range(0, NWORDS - 1));
            else if (r == 7) t = 32'(4 * $urandom_range(0, NWORDS - 1) + $urandom_range(1, 3));
            else if (r == 8) t = 32'(4 * NWORDS);
            else             t = $urandom;
            model_step(f, b, t);
            clock_with(f, b, t);
            check_state($sformatf("rnd%0d", c), m_pc, m_pc4, m_instr, m_valid, m_halted);
            if (m_halted && $urandom_range(0, 3) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
